// File: rtl/hsv_pwm_array.sv
// Multi-channel hue-wheel RGB PWM driver: a base hue steps around 0..359 degrees,
// each channel converts its offset hue to brightness-scaled RGB duties on active-low pins.
module hsv_pwm_array #(
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 33333,
  parameter int NUM_CH      = 1,
  parameter int CH_OFFSET   = 120
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                dir,
  input  logic                step,
  input  logic [PWM_BITS-1:0] bright,
  output logic [NUM_CH-1:0]   RGB_R,
  output logic [NUM_CH-1:0]   RGB_G,
  output logic [NUM_CH-1:0]   RGB_B,
  output logic [8:0]          hue,
  output logic                wrap
);

  localparam int PS_W = ($clog2(STEP_CYCLES) > 16) ? $clog2(STEP_CYCLES) : 16;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(STEP_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] MAX = {PWM_BITS{1'b1}};
  localparam int RW = PWM_BITS + 6;

  logic [PS_W-1:0]     ps_q, ps_d;
  logic [8:0]          hue_q, hue_d;
  logic                wrap_q, wrap_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic                tick, adv, latch;
  logic [PWM_BITS:0]   bright_p1;

  logic [NUM_CH-1:0][PWM_BITS-1:0] scaled_r, scaled_g, scaled_b;
  logic [NUM_CH-1:0][PWM_BITS-1:0] duty_r_q, duty_g_q, duty_b_q;
  logic [NUM_CH-1:0][PWM_BITS-1:0] duty_r_d, duty_g_d, duty_b_d;
  logic [NUM_CH-1:0]               rgb_r_q, rgb_g_q, rgb_b_q;
  logic [NUM_CH-1:0]               rgb_r_d, rgb_g_d, rgb_b_d;

  // raw * (bright + 1) never reaches 2^(2*PWM_BITS), so the product fits exactly.
  function automatic logic [PWM_BITS-1:0] scale(input logic [PWM_BITS-1:0] raw,
                                                input logic [PWM_BITS:0]   b1);
    logic [2*PWM_BITS-1:0] p;
    p = (2*PWM_BITS)'(raw) * (2*PWM_BITS)'(b1);
    return PWM_BITS'(p >> PWM_BITS);
  endfunction

  always_comb begin
    tick   = run && (ps_q == PS_LAST);
    ps_d   = (run && !tick) ? ps_q + 1'b1 : '0;
    // step only counts while stopped, so at most one advance per cycle
    adv    = tick || (step && !run);
    hue_d  = hue_q;
    wrap_d = 1'b0;
    if (adv) begin
      if (dir) begin
        if (hue_q == 9'd0) begin
          hue_d  = 9'd359;
          wrap_d = 1'b1;
        end else begin
          hue_d = hue_q - 1'b1;
        end
      end else begin
        if (hue_q == 9'd359) begin
          hue_d  = 9'd0;
          wrap_d = 1'b1;
        end else begin
          hue_d = hue_q + 1'b1;
        end
      end
    end
    cnt_d     = cnt_q + 1'b1;
    latch     = (cnt_q == MAX);
    bright_p1 = {1'b0, bright} + 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [8:0] OFF = 9'((i * CH_OFFSET) % 360);
    logic [9:0]          sum;
    logic [8:0]          h, base;
    logic [2:0]          sec;
    logic [5:0]          f;
    logic [RW-1:0]       prod, ramp_w;
    logic [PWM_BITS-1:0] ramp, raw_r, raw_g, raw_b;

    always_comb begin
      sum = {1'b0, hue_q} + {1'b0, OFF};
      h   = (sum >= 10'd360) ? 9'(sum - 10'd360) : sum[8:0];
      if (h < 9'd60) begin
        sec = 3'd0; base = 9'd0;
      end else if (h < 9'd120) begin
        sec = 3'd1; base = 9'd60;
      end else if (h < 9'd180) begin
        sec = 3'd2; base = 9'd120;
      end else if (h < 9'd240) begin
        sec = 3'd3; base = 9'd180;
      end else if (h < 9'd300) begin
        sec = 3'd4; base = 9'd240;
      end else begin
        sec = 3'd5; base = 9'd300;
      end
      f      = 6'(h - base);
      prod   = RW'(f) * RW'(MAX);
      ramp_w = prod / RW'(60);
      ramp   = PWM_BITS'(ramp_w);
      raw_r  = '0;
      raw_g  = '0;
      raw_b  = '0;
      case (sec)
        3'd0:    begin raw_r = MAX;        raw_g = ramp;       raw_b = '0;         end
        3'd1:    begin raw_r = MAX - ramp; raw_g = MAX;        raw_b = '0;         end
        3'd2:    begin raw_r = '0;         raw_g = MAX;        raw_b = ramp;       end
        3'd3:    begin raw_r = '0;         raw_g = MAX - ramp; raw_b = MAX;        end
        3'd4:    begin raw_r = ramp;       raw_g = '0;         raw_b = MAX;        end
        default: begin raw_r = MAX;        raw_g = '0;         raw_b = MAX - ramp; end
      endcase
    end

    assign scaled_r[i] = scale(raw_r, bright_p1);
    assign scaled_g[i] = scale(raw_g, bright_p1);
    assign scaled_b[i] = scale(raw_b, bright_p1);
  end

  // Duties only move at the period boundary, so a period is never cut short.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      duty_r_d[i] = latch ? scaled_r[i] : duty_r_q[i];
      duty_g_d[i] = latch ? scaled_g[i] : duty_g_q[i];
      duty_b_d[i] = latch ? scaled_b[i] : duty_b_q[i];
      rgb_r_d[i]  = ~(cnt_q < duty_r_q[i]);
      rgb_g_d[i]  = ~(cnt_q < duty_g_q[i]);
      rgb_b_d[i]  = ~(cnt_q < duty_b_q[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q     <= '0;
      hue_q    <= '0;
      wrap_q   <= 1'b0;
      cnt_q    <= '0;
      duty_r_q <= '0;
      duty_g_q <= '0;
      duty_b_q <= '0;
      rgb_r_q  <= '1;
      rgb_g_q  <= '1;
      rgb_b_q  <= '1;
    end else begin
      ps_q     <= ps_d;
      hue_q    <= hue_d;
      wrap_q   <= wrap_d;
      cnt_q    <= cnt_d;
      duty_r_q <= duty_r_d;
      duty_g_q <= duty_g_d;
      duty_b_q <= duty_b_d;
      rgb_r_q  <= rgb_r_d;
      rgb_g_q  <= rgb_g_d;
      rgb_b_q  <= rgb_b_d;
    end
  end

  assign RGB_R = rgb_r_q;
  assign RGB_G = rgb_g_q;
  assign RGB_B = rgb_b_q;
  assign hue   = hue_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_hsv_pwm_array.sv
// Directed bench for hsv_pwm_array with PWM_BITS=4, STEP_CYCLES=4, NUM_CH=2, CH_OFFSET=120.
module tb_hsv_pwm_array;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst, run, dir, step;
  logic [3:0] bright;
  logic [1:0] RGB_R, RGB_G, RGB_B;
  logic [8:0] hue;
  logic       wrap;

  int errors = 0;
  int checks = 0;
  int lo_r[2], lo_g[2], lo_b[2];
  int wraps;
  logic found;

  hsv_pwm_array #(
    .PWM_BITS(4), .STEP_CYCLES(4), .NUM_CH(2), .CH_OFFSET(120)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .dir(dir), .step(step), .bright(bright),
    .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B), .hue(hue), .wrap(wrap)
  );

  // clock / reset
  always #5 if (clk_en) clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic clear_lo();
    for (int c = 0; c < 2; c++) begin
      lo_r[c] = 0; lo_g[c] = 0; lo_b[c] = 0;
    end
  endtask

  task automatic sample();
    for (int c = 0; c < 2; c++) begin
      if (RGB_R[c] === 1'b0) lo_r[c]++;
      if (RGB_G[c] === 1'b0) lo_g[c]++;
      if (RGB_B[c] === 1'b0) lo_b[c]++;
    end
  endtask

  task automatic measure(input int n);
    repeat (n) begin
      @(negedge clk);
      sample();
    end
  endtask

  task automatic check_lo(input string tag, input int r0, input int g0, input int b0,
                          input int r1, input int g1, input int b1);
    check($sformatf("%s_r0", tag), lo_r[0], r0);
    check($sformatf("%s_g0", tag), lo_g[0], g0);
    check($sformatf("%s_b0", tag), lo_b[0], b0);
    check($sformatf("%s_r1", tag), lo_r[1], r1);
    check($sformatf("%s_g1", tag), lo_g[1], g1);
    check($sformatf("%s_b1", tag), lo_b[1], b1);
  endtask

  task automatic step_pulse();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Stops on the negedge showing the first low cycle of ch0 red (a period start).
  task automatic align(input string tag);
    logic prev;
    found = 1'b0;
    prev  = RGB_R[0];
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (prev === 1'b1 && RGB_R[0] === 1'b0) found = 1'b1;
      prev = RGB_R[0];
    end
    check(tag, found, 1);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; dir = 1'b0; step = 1'b0; bright = 4'd15;

    // reset with no clock
    #20;
    check("rst_r", RGB_R, 2'b11);
    check("rst_g", RGB_G, 2'b11);
    check("rst_b", RGB_B, 2'b11);
    check("rst_hue", hue, 0);
    check("rst_wrap", wrap, 0);

    clk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_lo();
    measure(16);
    check_lo("first_period", 0, 0, 0, 0, 0, 0);

    // hue 0: ch0 red full, ch1 (120) green full
    repeat (20) @(negedge clk);
    clear_lo();
    measure(16);
    check_lo("hue0", 15, 0, 0, 0, 15, 0);

    // hue 30: ramp = 30*15/60 = 7; ch1 at 150 has blue ramp 7
    repeat (30) step_pulse();
    check("hue30", hue, 30);
    repeat (40) @(negedge clk);
    clear_lo();
    measure(16);
    check_lo("hue30", 15, 7, 0, 0, 15, 7);

    // bright 7 halves duties, but only from the next period
    align("align_bright");
    clear_lo();
    sample();
    bright = 4'd7;
    measure(15);
    check_lo("bright_old", 15, 7, 0, 0, 15, 7);
    clear_lo();
    measure(16);
    check_lo("bright_new", 7, 3, 0, 0, 7, 3);

    // auto-run increment and wrap
    bright = 4'd15;
    do_reset();
    check("run_start_hue", hue, 0);
    run = 1'b1;
    wraps = 0;
    for (int k = 1; k <= 1444; k++) begin
      @(negedge clk);
      if (wrap === 1'b1) wraps++;
      if (k == 3) check("run_k3", hue, 0);
      if (k == 4) check("run_k4", hue, 1);
      if (k == 1439) check("run_k1439", hue, 359);
      if (k == 1440) begin
        check("run_k1440_hue", hue, 0);
        check("run_k1440_wrap", wrap, 1);
        check("run_wrap_count", wraps, 1);
        dir = 1'b1;
      end
      if (k == 1441) check("run_k1441_wrap", wrap, 0);
      if (k == 1443) check("dec_k1443", hue, 0);
      if (k == 1444) begin
        check("dec_k1444_hue", hue, 359);
        check("dec_k1444_wrap", wrap, 1);
      end
    end

    // step mode
    run = 1'b0;
    dir = 1'b0;
    do_reset();
    repeat (3) step_pulse();
    check("step3_hue", hue, 3);
    run = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 3) check("resume_k3", hue, 3);
      if (k == 4) check("resume_k4", hue, 4);
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check("step_in_run_1", hue, 4);
    repeat (2) @(negedge clk);
    check("step_in_run_3", hue, 4);
    @(negedge clk);
    check("step_in_run_4", hue, 5);
    run = 1'b0;
    dir = 1'b1;
    step_pulse();
    check("step_dec", hue, 4);

    // mid-run reset during a low (lit) phase
    dir = 1'b0;
    do_reset();
    repeat (5) step_pulse();
    check("pre_rst_hue", hue, 5);
    repeat (40) @(negedge clk);
    align("align_rst");
    check("pre_rst_r0_lit", RGB_R[0], 0);
    #1 rst = 1'b1;
    #1;
    check("midrst_r", RGB_R, 2'b11);
    check("midrst_g", RGB_G, 2'b11);
    check("midrst_b", RGB_B, 2'b11);
    check("midrst_hue", hue, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_lo();
    measure(16);
    check_lo("post_rst", 0, 0, 0, 0, 0, 0);
    check("post_rst_hue", hue, 0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hsv_pwm_array.md
# hsv_pwm_array

Parametrised multi-channel hue-wheel RGB PWM driver for the 12 MHz board designs. It advances a base hue through 0–359° at a programmable rate, with run, pause, single-step and reverse modes. Each of NUM_CH RGB LEDs gets a fixed hue offset, and each colour uses piecewise-linear HSV→RGB conversion with a global brightness scale. Duties are glitch-free because they are latched only at PWM period boundaries. Outputs are registered and active-low, and drive the LED pins directly.

## Interface
- PWM_BITS, 8: PWM resolution; legal range 4..12; MAX = 2^PWM_BITS−1.
- STEP_CYCLES, 33333: clk cycles per 1° hue step while running; must be ≥1.
- NUM_CH, 1: number of RGB LEDs; legal range 1..8.
- CH_OFFSET, 120: hue offset in degrees between consecutive channels; legal range 0..359.
- clk  in  1  system clock. One clock domain only.
- rst  in  1  reset, asynchronous and active-high.
- run  in  1  1 = hue auto-advances every STEP_CYCLES cycles.
- dir  in  1  0 = hue increments; 1 = hue decrements.
- step  in  1  single-cycle pulse; advances hue by 1° when run=0, ignored when run=1.
- bright  in  PWM_BITS  global brightness; MAX = full scale.
- RGB_R  out  NUM_CH  red, active-low; bit i is channel i.
- RGB_G  out  NUM_CH  green, active-low.
- RGB_B  out  NUM_CH  blue, active-low.
- hue  out  9  current base hue, 0..359.
- wrap  out  1  one-cycle pulse when hue wraps (359→0 incrementing, 0→359 decrementing).

## Operation
- Prescaler (16+ bits, sized from STEP_CYCLES) behaviour:
  - When run=1, it counts 0..STEP_CYCLES−1. At terminal count it returns to 0 and issues one hue advance.
  - When run=0, it is held at 0. Resuming therefore always gives a full STEP_CYCLES interval before the first advance.
- Hue advance moves hue ±1 mod 360 according to dir sampled that cycle. The wrap pulse is asserted on the same edge that loads the wrapped value.
- step and a prescaler tick can never both apply: step is ignored when run=1, so at most one advance per cycle.
- Channel i hue is h_i = (hue + i·CH_OFFSET) mod 360. Channel 0 equals hue.
- Conversion per channel, with s = h_i/60 (integer sector) and f = h_i − 60·s:
  - ramp = (f·MAX)/60, floor, computed at width ≥ PWM_BITS+6 bits.
  - s=0: R=MAX, G=ramp, B=0.
  - s=1: R=MAX−ramp, G=MAX, B=0.
  - s=2: R=0, G=MAX, B=ramp.
  - s=3: R=0, G=MAX−ramp, B=MAX.
  - s=4: R=ramp, G=0, B=MAX.
  - s=5: R=MAX, G=0, B=MAX−ramp.
- Brightness scaling: duty = (raw·(bright+1)) >> PWM_BITS. bright=MAX yields raw unchanged; bright=0 yields duty ≤ raw>>PWM_BITS, i.e. 0.
- PWM behaviour:
  - A single shared PWM_BITS counter free-runs 0..MAX and wraps.
  - Each colour's duty is latched into a duty register only on the cycle the counter equals MAX.
  - A colour is on when counter < latched duty. Full on is MAX/(MAX+1); duty 0 is always off.
- Output registers: RGB_x ← ~(counter < duty_latched), registered one cycle after the compare.

## Timing
- Reset (asynchronous, takes effect without a clock edge):
  - Prescaler, hue and PWM counter = 0; duty latches = 0.
  - RGB_R/G/B = all 1s (off); wrap = 0.
- After rst deasserts:
  - The first PWM period uses duty 0, so LEDs stay off for MAX+1 cycles.
  - The first real duties are latched at counter=MAX and appear on the pins from the period starting 1 cycle later.
- Hue advance latency:
  - With run=1, hue changes on the edge where the prescaler is at STEP_CYCLES−1, i.e. every STEP_CYCLES cycles after run rises.
  - With run=0, hue changes on the edge following a sampled step=1.
- Hue→pin latency: 1..MAX+1 cycles to the next latch, plus 1 output register cycle. A duty never changes mid-period; the same holds for bright changes.
- Reset mid-period: outputs go off immediately. No partial period completes afterwards.

## Test plan
- All scenarios use PWM_BITS=4, STEP_CYCLES=4, NUM_CH=2, CH_OFFSET=120, unless noted.
- Reset: assert rst with no clock running → RGB_R=RGB_G=RGB_B=2'b11, hue=0, wrap=0. Release rst → all LEDs off for the first 16 cycles.
- run=0, hue=0, bright=15:
  - Ch0: RGB_R low for exactly 15 of every 16 cycles; RGB_G and RGB_B constantly high.
  - Ch1 (hue 120): RGB_G low 15/16, with R and B off.
- Arithmetic: step to hue 30 with bright=15 → ch0 G duty 7 (low 7 of 16 cycles). Set bright=7 → G duty 3, with the change effective only from the next period boundary.
- run=1, dir=0:
  - hue increments every 4 cycles.
  - After 1440 cycles hue returns to 0 with exactly one wrap pulse.
  - With dir=1 from hue=0, hue reads 359 after 4 cycles, with a wrap pulse on that edge.
- Step mode:
  - With run=0, three step pulses → hue=3, and the prescaler stays at 0.
  - A step pulse with run=1 does not produce an extra advance.
- Mid-run reset: assert rst during a PWM high phase → outputs go high asynchronously; hue=0 on release.
